// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage: register file, decoder, load-use hazard and ID/EX register
module id_stage #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_instruction_i,
  input  logic [31:0] id_pc_i,
  input  logic [31:0] id_pc_add4_i,
  input  logic        id_exc_addr_i,
  input  logic        id_ready_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  input  logic        ex_flush_i,
  input  logic        ex_stall_i,
  output logic        id_stall_o,
  output logic        ex_valid_o,
  output logic [31:0] ex_pc_o,
  output logic [31:0] ex_pc_add4_o,
  output logic [31:0] ex_rs1_data_o,
  output logic [31:0] ex_rs2_data_o,
  output logic [31:0] ex_imm_o,
  output logic [4:0]  ex_rs1_o,
  output logic [4:0]  ex_rs2_o,
  output logic [4:0]  ex_rd_o,
  output logic [2:0]  ex_funct3_o,
  output logic [3:0]  ex_alu_op_o,
  output logic [7:0]  ex_ctrl_o,
  output logic        ex_exc_addr_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  function automatic logic [31:0] imm_of(input logic [31:0] inst);
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC: imm_of = {inst[31:12], 12'b0};
      OPC_JAL:    imm_of = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      OPC_BRANCH: imm_of = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_STORE:  imm_of = {{21{inst[31]}}, inst[30:25], inst[11:7]};
      default:    imm_of = {{21{inst[31]}}, inst[30:20]};
    endcase
  endfunction

  // inst[30] selects SUB only for register-register ops, SRA for both shift forms
  function automatic logic [3:0] alu_of(input logic [31:0] inst);
    logic is_op;
    is_op = (inst[6:0] == OPC_OP);
    alu_of = ALU_ADD;
    if (inst[6:0] == OPC_LUI) begin
      alu_of = ALU_PASSB;
    end else if (is_op || inst[6:0] == OPC_OPIMM) begin
      case (inst[14:12])
        3'b000:  alu_of = (is_op && inst[30]) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_of = ALU_SLL;
        3'b010:  alu_of = ALU_SLT;
        3'b011:  alu_of = ALU_SLTU;
        3'b100:  alu_of = ALU_XOR;
        3'b101:  alu_of = inst[30] ? ALU_SRA : ALU_SRL;
        3'b110:  alu_of = ALU_OR;
        default: alu_of = ALU_AND;
      endcase
    end
  endfunction

  function automatic logic [7:0] ctrl_of(input logic [31:0] inst);
    if (inst[1:0] != 2'b11) begin
      ctrl_of = 8'h80;
    end else begin
      case (inst[6:0])
        OPC_LUI:    ctrl_of = 8'h41;
        OPC_AUIPC:  ctrl_of = 8'h61;
        OPC_JAL:    ctrl_of = 8'h71;
        OPC_JALR:   ctrl_of = 8'h51;
        OPC_BRANCH: ctrl_of = 8'h08;
        OPC_LOAD:   ctrl_of = 8'h43;
        OPC_STORE:  ctrl_of = 8'h44;
        OPC_OPIMM:  ctrl_of = 8'h41;
        OPC_OP:     ctrl_of = 8'h01;
        OPC_MISC:   ctrl_of = 8'h00;
        OPC_SYSTEM: ctrl_of = 8'h00;
        default:    ctrl_of = 8'h80;
      endcase
    end
  endfunction

  logic [31:0] r_rf [32];

  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;
  logic        w_wb_active;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_load_use;
  logic        w_bubble;
  logic [31:0] w_nop_imm;
  logic [3:0]  w_nop_alu;

  assign w_rs1       = id_instruction_i[19:15];
  assign w_rs2       = id_instruction_i[24:20];
  assign w_wb_active = wb_we_i && (wb_rd_i != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= 32'd0;
    end else if (w_wb_active) begin
      r_rf[wb_rd_i] <= wb_data_i;
    end
  end

  // Writeback bypass so an instruction reading the register being written sees the new value
  assign w_rs1_data = (w_rs1 == 5'd0) ? 32'd0 :
                      (w_wb_active && wb_rd_i == w_rs1) ? wb_data_i : r_rf[w_rs1];
  assign w_rs2_data = (w_rs2 == 5'd0) ? 32'd0 :
                      (w_wb_active && wb_rd_i == w_rs2) ? wb_data_i : r_rf[w_rs2];

  assign w_use_rs1 = !(id_instruction_i[6:0] == OPC_LUI || id_instruction_i[6:0] == OPC_AUIPC ||
                       id_instruction_i[6:0] == OPC_JAL);
  assign w_use_rs2 = (id_instruction_i[6:0] == OPC_BRANCH || id_instruction_i[6:0] == OPC_STORE ||
                      id_instruction_i[6:0] == OPC_OP);

  assign w_load_use = ex_valid_o && ex_ctrl_o[1] && (ex_rd_o != 5'd0) &&
                      ((w_use_rs1 && ex_rd_o == w_rs1) || (w_use_rs2 && ex_rd_o == w_rs2));

  assign id_stall_o = !rst && !ex_flush_i && (w_load_use || ex_stall_i);

  assign w_nop_imm = imm_of(NOP_INST);
  assign w_nop_alu = alu_of(NOP_INST);
  assign w_bubble  = ex_flush_i || (!ex_stall_i && (w_load_use || !id_ready_i));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_o    <= 1'b0;
      ex_pc_o       <= 32'd0;
      ex_pc_add4_o  <= 32'd0;
      ex_rs1_data_o <= 32'd0;
      ex_rs2_data_o <= 32'd0;
      ex_imm_o      <= 32'd0;
      ex_rs1_o      <= 5'd0;
      ex_rs2_o      <= 5'd0;
      ex_rd_o       <= 5'd0;
      ex_funct3_o   <= 3'd0;
      ex_alu_op_o   <= 4'd0;
      ex_ctrl_o     <= 8'd0;
      ex_exc_addr_o <= 1'b0;
    end else if (w_bubble) begin
      ex_valid_o    <= 1'b0;
      ex_pc_o       <= 32'd0;
      ex_pc_add4_o  <= 32'd0;
      ex_rs1_data_o <= 32'd0;
      ex_rs2_data_o <= 32'd0;
      ex_imm_o      <= w_nop_imm;
      ex_rs1_o      <= NOP_INST[19:15];
      ex_rs2_o      <= NOP_INST[24:20];
      ex_rd_o       <= NOP_INST[11:7];
      ex_funct3_o   <= NOP_INST[14:12];
      ex_alu_op_o   <= w_nop_alu;
      ex_ctrl_o     <= 8'd0;
      ex_exc_addr_o <= 1'b0;
    end else if (!ex_stall_i) begin
      ex_valid_o    <= 1'b1;
      ex_pc_o       <= id_pc_i;
      ex_pc_add4_o  <= id_pc_add4_i;
      ex_rs1_data_o <= w_rs1_data;
      ex_rs2_data_o <= w_rs2_data;
      ex_imm_o      <= imm_of(id_instruction_i);
      ex_rs1_o      <= w_rs1;
      ex_rs2_o      <= w_rs2;
      ex_rd_o       <= id_instruction_i[11:7];
      ex_funct3_o   <= id_instruction_i[14:12];
      ex_alu_op_o   <= alu_of(id_instruction_i);
      ex_ctrl_o     <= ctrl_of(id_instruction_i);
      ex_exc_addr_o <= id_exc_addr_i;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed self-checking bench for id_stage
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_instruction_i;
  logic [31:0] id_pc_i;
  logic [31:0] id_pc_add4_i;
  logic        id_exc_addr_i;
  logic        id_ready_i;
  logic        wb_we_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        ex_flush_i;
  logic        ex_stall_i;
  logic        id_stall_o;
  logic        ex_valid_o;
  logic [31:0] ex_pc_o;
  logic [31:0] ex_pc_add4_o;
  logic [31:0] ex_rs1_data_o;
  logic [31:0] ex_rs2_data_o;
  logic [31:0] ex_imm_o;
  logic [4:0]  ex_rs1_o;
  logic [4:0]  ex_rs2_o;
  logic [4:0]  ex_rd_o;
  logic [2:0]  ex_funct3_o;
  logic [3:0]  ex_alu_op_o;
  logic [7:0]  ex_ctrl_o;
  logic        ex_exc_addr_o;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk              (clk),
    .rst              (rst),
    .id_instruction_i (id_instruction_i),
    .id_pc_i          (id_pc_i),
    .id_pc_add4_i     (id_pc_add4_i),
    .id_exc_addr_i    (id_exc_addr_i),
    .id_ready_i       (id_ready_i),
    .wb_we_i          (wb_we_i),
    .wb_rd_i          (wb_rd_i),
    .wb_data_i        (wb_data_i),
    .ex_flush_i       (ex_flush_i),
    .ex_stall_i       (ex_stall_i),
    .id_stall_o       (id_stall_o),
    .ex_valid_o       (ex_valid_o),
    .ex_pc_o          (ex_pc_o),
    .ex_pc_add4_o     (ex_pc_add4_o),
    .ex_rs1_data_o    (ex_rs1_data_o),
    .ex_rs2_data_o    (ex_rs2_data_o),
    .ex_imm_o         (ex_imm_o),
    .ex_rs1_o         (ex_rs1_o),
    .ex_rs2_o         (ex_rs2_o),
    .ex_rd_o          (ex_rd_o),
    .ex_funct3_o      (ex_funct3_o),
    .ex_alu_op_o      (ex_alu_op_o),
    .ex_ctrl_o        (ex_ctrl_o),
    .ex_exc_addr_o    (ex_exc_addr_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] inst, input logic [31:0] pc);
    id_instruction_i = inst;
    id_pc_i          = pc;
    id_pc_add4_i     = pc + 32'd4;
    id_ready_i       = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    id_instruction_i = 32'h0000_0013;
    id_pc_i = 32'd0;
    id_pc_add4_i = 32'd4;
    id_exc_addr_i = 1'b0;
    id_ready_i = 1'b0;
    wb_we_i = 1'b0;
    wb_rd_i = 5'd0;
    wb_data_i = 32'd0;
    ex_flush_i = 1'b0;
    ex_stall_i = 1'b0;

    tick;
    tick;
    chk("reset_valid", ex_valid_o, 0);
    chk("reset_stall", id_stall_o, 0);
    chk("reset_ctrl", ex_ctrl_o, 0);
    chk("reset_pc", ex_pc_o, 0);
    rst = 1'b0;

    // Write x1, read it back through ADD x2,x1,x0
    wb_we_i = 1'b1; wb_rd_i = 5'd1; wb_data_i = 32'h1234_5678;
    tick;
    wb_we_i = 1'b0;
    put(32'h0000_8133, 32'h0000_0040);
    tick;
    chk("x1_read", ex_rs1_data_o, 32'h1234_5678);
    chk("x1_valid", ex_valid_o, 1);
    chk("x1_pc_add4", ex_pc_add4_o, 32'h0000_0044);

    // Async reset mid-stall
    ex_stall_i = 1'b1;
    #1;
    chk("stall_pre_rst", id_stall_o, 1);
    rst = 1'b1;
    #1;
    chk("rst_stall_clear", id_stall_o, 0);
    chk("rst_valid_clear", ex_valid_o, 0);
    chk("rst_rs1data_clear", ex_rs1_data_o, 0);
    rst = 1'b0;
    ex_stall_i = 1'b0;
    tick;
    chk("x1_after_rst", ex_rs1_data_o, 0);
    chk("x1_after_rst_valid", ex_valid_o, 1);

    // ADDI x1,x0,5
    put(32'h0050_0093, 32'h0000_0100);
    id_exc_addr_i = 1'b1;
    tick;
    id_exc_addr_i = 1'b0;
    chk("addi_rd", ex_rd_o, 1);
    chk("addi_imm", ex_imm_o, 5);
    chk("addi_alu", ex_alu_op_o, 0);
    chk("addi_ctrl", ex_ctrl_o, 32'h41);
    chk("addi_pc", ex_pc_o, 32'h0000_0100);
    chk("addi_exc", ex_exc_addr_o, 1);

    // Writeback bypass: x5 written in the same cycle ADD x6,x5,x5 is decoded
    wb_we_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'hDEAD_BEEF;
    put(32'h0052_8333, 32'h0000_0104);
    tick;
    wb_we_i = 1'b0;
    chk("bypass_rs1", ex_rs1_data_o, 32'hDEAD_BEEF);
    chk("bypass_rs2", ex_rs2_data_o, 32'hDEAD_BEEF);
    chk("bypass_rd", ex_rd_o, 6);
    chk("bypass_ctrl", ex_ctrl_o, 32'h01);
    tick;
    chk("x5_stored", ex_rs2_data_o, 32'hDEAD_BEEF);

    // Load-use: LW x2,0(x1) then ADD x3,x2,x2
    put(32'h0000_A103, 32'h0000_0108);
    tick;
    chk("lw_ctrl", ex_ctrl_o, 32'h43);
    chk("lw_funct3", ex_funct3_o, 2);
    put(32'h0021_01B3, 32'h0000_010C);
    #1;
    chk("lu_stall", id_stall_o, 1);
    tick;
    chk("lu_bubble_valid", ex_valid_o, 0);
    chk("lu_bubble_ctrl", ex_ctrl_o, 0);
    chk("lu_bubble_rd", ex_rd_o, 0);
    chk("lu_stall_released", id_stall_o, 0);
    tick;
    chk("lu_add_valid", ex_valid_o, 1);
    chk("lu_add_rd", ex_rd_o, 3);
    chk("lu_add_rs2", ex_rs2_o, 2);

    // EX stall holds ID/EX; flush together with stall gives a bubble and no stall
    put(32'h4020_82B3, 32'h0000_0110);
    ex_stall_i = 1'b1;
    tick;
    chk("hold_rd", ex_rd_o, 3);
    chk("hold_stall", id_stall_o, 1);
    ex_flush_i = 1'b1;
    #1;
    chk("flush_stall_o", id_stall_o, 0);
    tick;
    chk("flush_valid", ex_valid_o, 0);
    chk("flush_ctrl", ex_ctrl_o, 0);
    ex_flush_i = 1'b0;
    ex_stall_i = 1'b0;

    // SUB x5,x1,x2
    tick;
    chk("sub_alu", ex_alu_op_o, 1);
    chk("sub_rd", ex_rd_o, 5);

    // BEQ x1,x2,+8
    put(32'h0020_8463, 32'h0000_0114);
    tick;
    chk("beq_imm", ex_imm_o, 8);
    chk("beq_ctrl", ex_ctrl_o, 32'h08);

    // SW x2,4(x1)
    put(32'h0020_A223, 32'h0000_0118);
    tick;
    chk("sw_imm", ex_imm_o, 4);
    chk("sw_ctrl", ex_ctrl_o, 32'h44);

    // ADDI x1,x0,-1
    put(32'hFFF0_0093, 32'h0000_011C);
    tick;
    chk("addi_neg_imm", ex_imm_o, 32'hFFFF_FFFF);

    // LUI x4,0x12345
    put(32'h1234_5237, 32'h0000_0120);
    tick;
    chk("lui_imm", ex_imm_o, 32'h1234_5000);
    chk("lui_alu", ex_alu_op_o, 10);
    chk("lui_rd", ex_rd_o, 4);

    // Illegal word
    put(32'hFFFF_FFFF, 32'h0000_0124);
    tick;
    chk("illegal_ctrl", ex_ctrl_o, 32'h80);
    chk("illegal_valid", ex_valid_o, 1);

    // Write to x0 is ignored
    wb_we_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'hFFFF_FFFF;
    put(32'h0000_03B3, 32'h0000_0128);
    tick;
    wb_we_i = 1'b0;
    chk("x0_bypass", ex_rs1_data_o, 0);
    tick;
    chk("x0_read", ex_rs2_data_o, 0);

    // id_ready_i low inserts a bubble
    id_ready_i = 1'b0;
    tick;
    chk("notready_valid", ex_valid_o, 0);
    chk("notready_ctrl", ex_ctrl_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter NOP_INST, default 32'h0000_0013, the instruction word recorded in the ID/EX register for every bubble.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 id_instruction_i  in  32  instruction from the IF/ID register.
REQ-005 id_pc_i  in  32  PC of that instruction.
REQ-006 id_pc_add4_i  in  32  PC+4 of that instruction.
REQ-007 id_exc_addr_i  in  1  instruction-address-misaligned flag from fetch.
REQ-008 id_ready_i  in  1  IF/ID contents valid.
REQ-009 wb_we_i  in  1  writeback register-file write enable.
REQ-010 wb_rd_i  in  5  writeback destination register.
REQ-011 wb_data_i  in  32  writeback data.
REQ-012 ex_flush_i  in  1  taken branch/jump/exception from EX; kill the instruction in ID.
REQ-013 ex_stall_i  in  1  EX/MEM cannot accept; hold ID/EX.
REQ-014 id_stall_o  out  1  stall request to IF/ID and PC register.
REQ-015 ex_valid_o  out  1  ID/EX holds a real instruction.
REQ-016 ex_pc_o  out  32  registered PC.
REQ-017 ex_pc_add4_o  out  32  registered PC+4.
REQ-018 ex_rs1_data_o  out  32  registered rs1 operand.
REQ-019 ex_rs2_data_o  out  32  registered rs2 operand.
REQ-020 ex_imm_o  out  32  registered sign-extended immediate.
REQ-021 ex_rs1_o / ex_rs2_o / ex_rd_o  out  5 each  registered register indices.
REQ-022 ex_funct3_o  out  3  registered funct3.
REQ-023 ex_alu_op_o  out  4  ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 PASSB=10.
REQ-024 ex_ctrl_o  out  8  [0]reg_write [1]mem_read [2]mem_write [3]branch [4]jump [5]src_a_pc [6]src_b_imm [7]illegal.
REQ-025 ex_exc_addr_o  out  1  registered misaligned-fetch flag.

Function
REQ-026 Register file: 32x32; x0 reads 0; written on rising edge when wb_we_i=1 and wb_rd_i!=0.
REQ-027 Read bypass: if wb_we_i=1, wb_rd_i!=0 and wb_rd_i equals the source index, the operand is wb_data_i in the same cycle.
REQ-028 Decode RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM (as NOP), SYSTEM; immediates I/S/B/U/J sign-extended to 32 bits.
REQ-029 LUI uses PASSB. Every other non-OP/OP-IMM instruction uses ADD. AUIPC/JAL set src_a_pc. JAL/JALR set jump. BRANCH sets branch.
REQ-030 Illegal: inst[1:0]!=2'b11 or unlisted opcode -> illegal=1, reg_write/mem_read/mem_write=0.
REQ-031 Usage: rs1 used by all except LUI/AUIPC/JAL; rs2 used by BRANCH/STORE/OP only.
REQ-032 Load-use: ex_valid_o & mem_read & ex_rd_o!=0 & ex_rd_o matches a used rs -> id_stall_o=1 and bubble inserted, exactly one cycle.
REQ-033 id_stall_o = load-use | ex_stall_i; it SHALL be forced 0 while ex_flush_i=1.
REQ-034 ID/EX update priority per edge: ex_flush_i -> bubble; else ex_stall_i -> hold; else load-use -> bubble; else id_ready_i=0 -> bubble; else load decoded instruction.
REQ-035 Bubble: ex_valid_o=0, ex_ctrl_o=0, ex_exc_addr_o=0, fields from NOP_INST.
REQ-036 Latency: one cycle from id_* inputs to ex_* outputs.

Reset
REQ-037 While rst=1 (asynchronous), all ex_* outputs, ex_valid_o and all 32 registers SHALL be 0, and id_stall_o SHALL be 0; rst asserted mid-stall clears the stall immediately.

Verification
REQ-038 Write x1 via WB, assert rst mid-run -> ex_valid_o=0 at once, reading x1 afterwards returns 0.
REQ-039 0x00500093 (ADDI x1,x0,5), id_ready_i=1 -> next edge: ex_rd_o=1, ex_imm_o=5, ex_alu_op_o=0, ex_ctrl_o=8'h41.
REQ-040 wb x5=0xDEADBEEF in the same cycle as 0x00528333 (ADD x6,x5,x5) -> ex_rs1_data_o=ex_rs2_data_o=0xDEADBEEF.
REQ-041 0x0000A103 (LW x2,0(x1)) then 0x002101B3 (ADD x3,x2,x2) -> id_stall_o=1 for one cycle, a bubble is inserted, then the ADD issues with ex_rd_o=3.
REQ-042 ex_flush_i=1 and ex_stall_i=1 together -> bubble, id_stall_o=0. Also: 0xFFFFFFFF gives ex_ctrl_o=8'h80. Also: WB write to x0 reads back 0.
